// File: rtl/uart_tty_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tty_pkg
// Description : Shared types and constants for the uart_tty console UART.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tty_pkg;

    // Payload bits per 8N1 frame
    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    // Transmit FSM states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Receive FSM states
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tty_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tty_if
// Description : Host-side byte interface of uart_tty (TX handshake, RX strobe).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tty_if;
    import uart_tty_pkg::*;

    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_frame_err;

    // Host side: offers bytes, consumes received strobes
    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  rx_valid,
        input  rx_data,
        input  rx_frame_err
    );

    // UART side
    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output rx_valid,
        output rx_data,
        output rx_frame_err
    );

endinterface
`default_nettype wire

// File: rtl/uart_tty_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tty_rx
// Description : 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM and
//               registered byte/strobe/framing-error outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tty_rx
    import uart_tty_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  wire                  clk,
    input  wire                  rst_n,
    input  wire                  SRX,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err
);

    localparam int                 c_CNT_W    = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] c_BIT_LAST = BIT_IDX_W'(DATA_BITS - 1);

    logic                 r_sync1_q, w_sync1_d;
    logic                 r_sync2_q, w_sync2_d;
    rx_state_t            r_state_q, w_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [BIT_IDX_W-1:0] r_bit_q, w_bit_d;
    logic [DATA_BITS-1:0] r_shift_q, w_shift_d;
    logic                 r_valid_q, w_valid_d;
    logic [DATA_BITS-1:0] r_data_q, w_data_d;
    logic                 r_err_q, w_err_d;
    logic                 w_srx_s;

    assign w_srx_s = r_sync2_q;

    // Next-state logic: synchronizer shift plus receive FSM sampling at bit centres
    always_comb begin
        w_sync1_d = SRX;
        w_sync2_d = r_sync1_q;
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q + 1'b1;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_valid_d = 1'b0;
        w_data_d  = r_data_q;
        w_err_d   = r_err_q;
        case (r_state_q)
            RX_IDLE: begin
                w_cnt_d = '0;
                if (!w_srx_s) begin
                    w_state_d = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: confirm the start bit is still low
                if (r_cnt_q == c_CNT_HALF) begin
                    w_cnt_d = '0;
                    w_bit_d = '0;
                    w_state_d = w_srx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt_q == c_CNT_LAST) begin
                    w_cnt_d   = '0;
                    w_shift_d = {w_srx_s, r_shift_q[DATA_BITS-1:1]};
                    if (r_bit_q == c_BIT_LAST) begin
                        w_state_d = RX_STOP;
                    end else begin
                        w_bit_d = r_bit_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (r_cnt_q == c_CNT_LAST) begin
                    w_cnt_d   = '0;
                    w_data_d  = r_shift_q;
                    w_valid_d = 1'b1;
                    w_err_d   = !w_srx_s;
                    // A low stop bit means the line may be held low (break);
                    // refuse to treat that as a new start bit.
                    w_state_d = w_srx_s ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                w_cnt_d = '0;
                if (w_srx_s) begin
                    w_state_d = RX_IDLE;
                end
            end
            default: begin
                w_cnt_d   = '0;
                w_state_d = RX_IDLE;
            end
        endcase
    end

    // State registers; synchronizer resets to the idle-high line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1_q <= 1'b1;
            r_sync2_q <= 1'b1;
            r_state_q <= RX_IDLE;
            r_cnt_q   <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_valid_q <= w_valid_d;
            r_data_q  <= w_data_d;
            r_err_q   <= w_err_d;
        end
    end

    assign rx_valid     = r_valid_q;
    assign rx_data      = r_data_q;
    assign rx_frame_err = r_err_q;

endmodule
`default_nettype wire

// File: rtl/uart_tty.sv
`default_nettype none
// ============================================================================
// Module      : uart_tty
// Description : Full-duplex 8N1 console UART endpoint. Inline transmitter,
//               receiver in uart_tty_rx. Fixed clock divisor per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tty
    import uart_tty_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  wire        clk,
    input  wire        rst_n,
    input  wire        SRX,
    output logic       STX,
    uart_tty_if.slave  bus
);

    localparam int                   c_CNT_W    = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_IDX_W-1:0] c_BIT_LAST = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_t            r_tx_state_q, w_tx_state_d;
    logic [c_CNT_W-1:0]   r_tx_cnt_q, w_tx_cnt_d;
    logic [BIT_IDX_W-1:0] r_tx_bit_q, w_tx_bit_d;
    logic [DATA_BITS-1:0] r_tx_shift_q, w_tx_shift_d;
    logic                 r_stx_q, w_stx_d;
    logic                 r_tx_ready_q, w_tx_ready_d;

    logic                 w_rx_valid;
    logic [DATA_BITS-1:0] w_rx_data;
    logic                 w_rx_frame_err;

    // Transmit FSM: STX and tx_ready are computed one cycle ahead so both
    // change exactly at bit boundaries from flops.
    always_comb begin
        w_tx_state_d = r_tx_state_q;
        w_tx_cnt_d   = r_tx_cnt_q + 1'b1;
        w_tx_bit_d   = r_tx_bit_q;
        w_tx_shift_d = r_tx_shift_q;
        w_stx_d      = r_stx_q;
        w_tx_ready_d = r_tx_ready_q;
        case (r_tx_state_q)
            TX_IDLE: begin
                w_tx_cnt_d = '0;
                if (bus.tx_valid && r_tx_ready_q) begin
                    w_tx_shift_d = bus.tx_data;
                    w_tx_state_d = TX_START;
                    w_stx_d      = 1'b0;
                    w_tx_ready_d = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt_q == c_CNT_LAST) begin
                    w_tx_cnt_d   = '0;
                    w_tx_bit_d   = '0;
                    w_stx_d      = r_tx_shift_q[0];
                    w_tx_shift_d = r_tx_shift_q >> 1;
                    w_tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt_q == c_CNT_LAST) begin
                    w_tx_cnt_d = '0;
                    if (r_tx_bit_q == c_BIT_LAST) begin
                        w_stx_d      = 1'b1;
                        w_tx_state_d = TX_STOP;
                    end else begin
                        w_tx_bit_d   = r_tx_bit_q + 1'b1;
                        w_stx_d      = r_tx_shift_q[0];
                        w_tx_shift_d = r_tx_shift_q >> 1;
                    end
                end
            end
            TX_STOP: begin
                if (r_tx_cnt_q == c_CNT_LAST) begin
                    w_tx_cnt_d   = '0;
                    w_tx_ready_d = 1'b1;
                    w_tx_state_d = TX_IDLE;
                end
            end
            default: begin
                w_tx_cnt_d   = '0;
                w_stx_d      = 1'b1;
                w_tx_ready_d = 1'b1;
                w_tx_state_d = TX_IDLE;
            end
        endcase
    end

    // Transmit state registers; reset returns the line to idle-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state_q <= TX_IDLE;
            r_tx_cnt_q   <= '0;
            r_tx_bit_q   <= '0;
            r_tx_shift_q <= '0;
            r_stx_q      <= 1'b1;
            r_tx_ready_q <= 1'b1;
        end else begin
            r_tx_state_q <= w_tx_state_d;
            r_tx_cnt_q   <= w_tx_cnt_d;
            r_tx_bit_q   <= w_tx_bit_d;
            r_tx_shift_q <= w_tx_shift_d;
            r_stx_q      <= w_stx_d;
            r_tx_ready_q <= w_tx_ready_d;
        end
    end

    assign STX          = r_stx_q;
    assign bus.tx_ready = r_tx_ready_q;

    uart_tty_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .SRX          (SRX),
        .rx_valid     (w_rx_valid),
        .rx_data      (w_rx_data),
        .rx_frame_err (w_rx_frame_err)
    );

    assign bus.rx_valid     = w_rx_valid;
    assign bus.rx_data      = w_rx_data;
    assign bus.rx_frame_err = w_rx_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tty.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tty
// Description : Scoreboard bench for uart_tty with CLK_DIV=16: random and
//               directed TX/RX traffic against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tty;

    localparam int D = 16;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic srx_drv = 1'b1;
    logic loop_en = 1'b0;
    logic stx;
    logic srx;

    assign srx = loop_en ? stx : srx_drv;

    uart_tty_if bus ();

    uart_tty #(
        .CLK_DIV (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .SRX   (srx),
        .STX   (stx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    // {frame_err, data} expected from the receiver, in arrival order
    logic [8:0] rx_exp[$];
    // cycle numbers of accepted TX handshakes
    longint     hs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Receive monitor: every strobe must match the oldest expected frame
    initial begin : rx_mon
        logic       prev;
        logic [8:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rx_valid) begin
                chk("rx_valid_width", {31'd0, prev}, 32'd0);
                if (rx_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected: got data=0x%0h err=%0b expected no frame",
                             bus.rx_data, bus.rx_frame_err);
                end else begin
                    e = rx_exp.pop_front();
                    chk("rx_data", {24'd0, bus.rx_data}, {24'd0, e[7:0]});
                    chk("rx_frame_err", {31'd0, bus.rx_frame_err}, {31'd0, e[8]});
                end
            end
            prev = rst_n ? bus.rx_valid : 1'b0;
        end
    end

    // Transmit monitor: after a handshake the line must carry start, 8 data
    // bits LSB first and stop, each D cycles, with tx_ready low throughout.
    initial begin : tx_mon
        logic [9:0] fr;
        int         pos;
        bit         in_frame;
        bit         ready_due;
        fr        = '1;
        pos       = 0;
        in_frame  = 0;
        ready_due = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame  = 0;
                ready_due = 0;
            end else if (in_frame) begin
                pos++;
                chk("stx_bit", {31'd0, stx}, {31'd0, fr[(pos - 1) / D]});
                chk("tx_ready_busy", {31'd0, bus.tx_ready}, 32'd0);
                if (pos == 10 * D) begin
                    in_frame  = 0;
                    ready_due = 1;
                end
            end else begin
                chk("stx_idle", {31'd0, stx}, 32'd1);
                if (ready_due) begin
                    chk("tx_ready_after_stop", {31'd0, bus.tx_ready}, 32'd1);
                    ready_due = 0;
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    fr       = {1'b1, bus.tx_data, 1'b0};
                    in_frame = 1;
                    pos      = 0;
                    hs_cyc.push_back(cyc);
                    if (loop_en) rx_exp.push_back({1'b0, bus.tx_data});
                end
            end
        end
    end

    // Wait at a negedge for tx_ready; returns at the handshake cycle
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.tx_ready && n < 12 * D) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got tx_ready=0 expected 1 within %0d cycles", name, 12 * D);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        wait_ready("send");
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    task automatic wait_rx_drain(input string name);
        int n;
        n = 0;
        while (rx_exp.size() != 0 && n < 14 * D) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_exp.size() != 0) begin
            failures++;
            $display("FAIL %s_rx_timeout: got %0d frames pending expected 0", name, rx_exp.size());
            rx_exp.delete();
        end
    endtask

    // Drive one frame on SRX; the line is left at the stop level
    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        rx_exp.push_back({~stop, b});
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            srx_drv = fr[i];
            repeat (D) @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #(600_000);
        $display("FAIL watchdog: got no completion expected finish before 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] b;
        logic       stop;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        // Asynchronous reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("reset_stx", {31'd0, stx}, 32'd1);
        chk("reset_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
        chk("reset_rx_frame_err", {31'd0, bus.rx_frame_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // TX 0x55 in loopback, then 0xA3 with hold check on rx_data
        loop_en = 1'b1;
        send(8'h55);
        wait_rx_drain("tx55");
        send(8'hA3);
        wait_rx_drain("loop_a3");
        repeat (3 * D) @(posedge clk);
        @(negedge clk);
        chk("rx_data_hold", {24'd0, bus.rx_data}, 32'h0000_00A3);
        chk("rx_err_hold", {31'd0, bus.rx_frame_err}, 32'd0);

        // Random loopback bytes
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom));
            wait_rx_drain("loop_rand");
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        // Back-to-back: tx_valid held across two frames
        @(posedge clk); #1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h0D;
        wait_ready("b2b_first");
        @(posedge clk); #1;
        bus.tx_data = 8'h0A;
        wait_ready("b2b_second");
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
        wait_rx_drain("b2b");
        chk("b2b_gap", 32'(hs_cyc[hs_cyc.size() - 1] - hs_cyc[hs_cyc.size() - 2]), 32'(10 * D + 1));

        // Glitch shorter than half a bit, then a real frame
        loop_en = 1'b0;
        @(posedge clk); #1;
        srx_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1 srx_drv = 1'b1;
        repeat (3 * D) @(posedge clk);
        drive_frame(8'h41, 1'b1);
        wait_rx_drain("glitch_then_41");

        // Framing error with the line held low afterwards
        drive_frame(8'h00, 1'b0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("ferr_pending", 32'(rx_exp.size()), 32'd0);
        @(posedge clk); #1;
        srx_drv = 1'b1;
        repeat (D) @(posedge clk);
        drive_frame(8'h0D, 1'b1);
        wait_rx_drain("ferr_then_0d");

        // Random driven frames, some with a bad stop bit
        for (int i = 0; i < 5; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            drive_frame(b, stop);
            srx_drv = 1'b1;
            repeat ($urandom_range(2, D)) @(posedge clk);
            wait_rx_drain("drv_rand");
        end

        // Leave a nonzero byte and a set error flag, then reset mid-TX-frame
        drive_frame(8'h96, 1'b0);
        srx_drv = 1'b1;
        repeat (D) @(posedge clk);
        wait_rx_drain("pre_reset");
        loop_en = 1'b1;
        send(8'hC3);
        repeat (50) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midframe_reset_stx", {31'd0, stx}, 32'd1);
        chk("midframe_reset_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("midframe_reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("midframe_reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
        chk("midframe_reset_rx_err", {31'd0, bus.rx_frame_err}, 32'd0);
        rx_exp.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Recovery after reset
        send(8'($urandom));
        wait_rx_drain("post_reset");
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
